inv_pipeline: RTL and testbench

INV_PIPELINE -- requirements
Module: inv_pipeline

---
 rtl/inv_pipeline_pkg.sv | 14 +
 rtl/inv_stage.sv | 49 ++++
 rtl/inv_pipeline.sv | 95 +++++++++
 tb/tb_inv_pipeline.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/inv_pipeline_pkg.sv
// rtl/inv_pipeline_pkg.sv - shared mode encoding and counter constants for inv_pipeline
package inv_pipeline_pkg;

    typedef enum logic [1:0] {
        INV     = 2'd0,
        PASS    = 2'd1,
        MASKINV = 2'd2,
        ZERO    = 2'd3
    } mode_t;

    localparam int COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/inv_stage.sv
// rtl/inv_stage.sv - one elastic register stage: valid bit, data word and advance logic
module inv_stage
    import inv_pipeline_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             down_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             advance_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // An empty stage can always load; a full one only when its word moves on.
    assign advance_o = !valid_q || down_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (advance_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/inv_pipeline.sv
// rtl/inv_pipeline.sv - DEPTH-stage elastic pipeline applying INV/PASS/MASKINV/ZERO to each word
module inv_pipeline
    import inv_pipeline_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_mode,
    input  logic [WIDTH-1:0]   in_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] out_count
);

    logic [WIDTH-1:0]   result;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    always_comb begin
        result = '0;
        case (mode_t'(in_mode))
            INV:     result = ~in_data;
            PASS:    result = in_data;
            MASKINV: result = in_data ^ in_mask;
            ZERO:    result = '0;
            default: result = '0;
        endcase
    end

    // Each stage sees its upstream neighbour's word and its downstream neighbour's advance.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_ready;
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             advance;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = result;
        end else begin : g_link
            assign up_valid = g_stage[i-1].valid;
            assign up_data  = g_stage[i-1].data;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_mid
            assign down_ready = g_stage[i+1].advance;
        end

        inv_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk_i       (clk),
            .rst_i       (rst),
            .up_valid_i  (up_valid),
            .up_data_i   (up_data),
            .down_ready_i(down_ready),
            .valid_o     (valid),
            .data_o      (data),
            .advance_o   (advance)
        );
    end

    assign in_ready  = !g_stage[0].valid || g_stage[0].advance;
    assign out_valid = g_stage[DEPTH-1].valid;
    assign out_data  = g_stage[DEPTH-1].data;

    // Delivery counter sticks at its maximum rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (out_valid && out_ready && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;

endmodule

// File: tb/tb_inv_pipeline.sv
// tb/tb_inv_pipeline.sv - directed self-checking bench for inv_pipeline (WIDTH=8, DEPTH=3)
module tb_inv_pipeline;
    import inv_pipeline_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [15:0]      out_count;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         occ = 0;
    bit         did_acc = 1'b0;
    bit         chk_ready = 1'b0;
    bit         saw_full = 1'b0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [31:0] bp_pat = 32'b1100_0010_1101_0000_1011_0001_1110_0001;

    inv_pipeline #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .in_mask  (in_mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are set after a rising edge; handshakes are observed at the falling edge.
    task automatic tick();
        @(negedge clk);
        did_acc = !rst && in_valid && in_ready;
        if (chk_ready) begin
            check("in_ready_stall", 32'(in_ready), (occ == DEPTH && !out_ready) ? 32'd0 : 32'd1);
            if (occ == DEPTH && !out_ready) saw_full = 1'b1;
        end
        if (did_acc) begin
            occ++;
            acc_cyc = cyc;
        end
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
            occ--;
        end
        if (rst) occ = 0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        in_mask   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset and idle state
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        cyc++;

        // Latency: 0F in INV -> F0 three cycles after acceptance
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        in_mode   = INV;
        tick();
        check("lat_accept", 32'(did_acc), 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && got_q.size() < 1; k++) tick();
        check("lat_count_results", got_q.size(), 32'd1);
        if (got_q.size() >= 1) begin
            check("lat_data", 32'(got_q[0]), 32'hF0);
            check("lat_cycles", 32'(got_cyc[0] - acc_cyc), 32'd3);
        end
        check("lat_out_count", 32'(out_count), 32'd1);

        // Modes back to back: PASS, MASKINV(mask F0), ZERO
        got_q.delete();
        got_cyc.delete();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_mode  = PASS;
        tick();
        in_mode  = MASKINV;
        in_mask  = 8'hF0;
        tick();
        in_mode  = ZERO;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && got_q.size() < 3; k++) tick();
        check("mode_results", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            check("mode_pass", 32'(got_q[0]), 32'hA5);
            check("mode_maskinv", 32'(got_q[1]), 32'h55);
            check("mode_zero", 32'(got_q[2]), 32'h00);
            check("mode_gap1", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
            check("mode_gap2", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
        end
        check("mode_out_count", 32'(out_count), 32'd4);

        // Backpressure: 00..09 in INV with a fixed irregular out_ready pattern
        got_q.delete();
        got_cyc.delete();
        idx = 0;
        in_mode = INV;
        chk_ready = 1'b1;
        for (int k = 0; k < 300 && got_q.size() < 10; k++) begin
            out_ready = bp_pat[cyc % 32];
            in_valid  = (idx < 10);
            in_data   = 8'(idx);
            tick();
            if (did_acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk_ready = 1'b0;
        check("bp_results", got_q.size(), 32'd10);
        check("bp_full_seen", 32'(saw_full), 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (k < got_q.size()) check($sformatf("bp_word%0d", k), 32'(got_q[k]), 32'(8'hFF - 8'(k)));
        end
        check("bp_out_count", 32'(out_count), 32'd14);

        // Reset mid-stream discards in-flight words and the word offered during reset
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = PASS;
        in_data   = 8'h11;
        tick();
        check("mid_accept1", 32'(did_acc), 32'd1);
        in_data = 8'h22;
        tick();
        check("mid_accept2", 32'(did_acc), 32'd1);
        rst     = 1'b1;
        in_data = 8'h33;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        got_cyc.delete();
        repeat (8) tick();
        check("mid_results", got_q.size(), 32'd0);
        check("mid_out_count", 32'(out_count), 32'd0);
        check("mid_out_valid", 32'(out_valid), 32'd0);

        // Saturation: continuous stream until the counter reaches FFFF, then keep delivering
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_mode   = PASS;
        out_ready = 1'b1;
        n = 0;
        while (out_count != 16'hFFFF && n < 70000) begin
            @(posedge clk);
            #1;
            cyc++;
            n++;
        end
        check("sat_cycles", 32'(n), 32'd65538);
        check("sat_reach", 32'(out_count), 32'hFFFF);
        repeat (3) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("sat_out_valid", 32'(out_valid), 32'd1);
        check("sat_hold", 32'(out_count), 32'hFFFF);
        check("sat_data", 32'(out_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
